// File: rtl/ab_resp_pkg.sv
// Shared types and constants for the ab_responder request/acknowledge handshake.
package ab_resp_pkg;

    // Width of the latency down-counter (supports LAT up to 15)
    localparam int LAT_W = 4;

    // Default saturation value of the completed-transaction counter
    localparam int R_MAX_DEF = 32'h7FFF_FFFF;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } ab_state_e;

    // Saturating increment: never exceeds lim, so the count cannot wrap negative
    function automatic logic signed [31:0] sat_inc(
        input logic signed [31:0] val,
        input logic signed [31:0] lim
    );
        logic signed [31:0] res;
        if (val < lim) begin
            res = val + 32'sd1;
        end else begin
            res = lim;
        end
        return res;
    endfunction

endpackage

// File: rtl/ab_lat_cnt.sv
// Loadable down-counter with a registered zero flag; stops at zero.
module ab_lat_cnt
    import ab_resp_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic             r_zero;

    // Next count: a load wins over a decrement; decrement holds at zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (i_dec && (r_cnt != {LAT_W{1'b0}})) begin
            w_cnt_nxt = r_cnt - LAT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count register with the zero flag registered alongside it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= {LAT_W{1'b0}};
            r_zero <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_zero <= (w_cnt_nxt == {LAT_W{1'b0}});
        end
    end

    assign o_zero = r_zero;

endmodule

// File: rtl/ab_responder.sv
// ab_responder: request/acknowledge responder with programmable latency,
// abort, one-cycle done pulse and a saturating completion counter.
// Optional macro AB_RESPONDER_SVA_EN embeds protocol assertions.
module ab_responder
    import ab_resp_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int R_MAX = R_MAX_DEF
) (
    input  logic               clk_top,
    input  logic               reset_n,
    input  logic               a1,
    input  logic               b1,
    output logic               c1,
    output logic               d1,
    output logic signed [31:0] r1
);

    // WAIT lasts LAT cycles: the counter starts at LAT-1 and ACK follows zero
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT - 1);

    ab_state_e          r_state;
    ab_state_e          w_state_nxt;
    logic               w_load;
    logic               w_dec;
    logic               w_cnt_zero;
    logic               r_c1;
    logic               r_d1;
    logic signed [31:0] r_r1;

    ab_lat_cnt u_lat_cnt (
        .i_clk      (clk_top),
        .i_rst_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and counter control; abort (b1) has priority everywhere
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (a1 && !b1) begin
                    w_state_nxt = WAIT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (b1) begin
                    w_state_nxt = IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ACK;
                end else begin
                    w_state_nxt = WAIT;
                    w_dec       = 1'b1;
                end
            end
            ACK: begin
                if (b1) begin
                    w_state_nxt = IDLE;
                end else if (!a1) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACK;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, registered handshake outputs and saturating completion count
    always_ff @(posedge clk_top) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_c1    <= 1'b0;
            r_d1    <= 1'b0;
            r_r1    <= 32'sd0;
        end else begin
            r_state <= w_state_nxt;
            r_c1    <= (w_state_nxt == ACK);
            r_d1    <= (w_state_nxt == DONE);
            if (w_state_nxt == DONE) begin
                r_r1 <= sat_inc(r_r1, R_MAX);
            end else begin
                r_r1 <= r_r1;
            end
        end
    end

    assign c1 = r_c1;
    assign d1 = r_d1;
    assign r1 = r_r1;

`ifdef AB_RESPONDER_SVA_EN
    logic w_accept;
    assign w_accept = (r_state == IDLE) && a1 && !b1;

    default clocking cb_sva @(posedge clk_top);
    endclocking
    default disable iff (!reset_n);

    a_lat_to_ack:   assert property (w_accept ##1 (!b1) [*LAT] |=> $rose(c1));
    a_d1_pulse:     assert property (d1 |=> !d1);
    a_c1_d1_excl:   assert property (!(c1 && d1));
    a_r1_monotonic: assert property (1'b1 |=> (r1 >= $past(r1)));
`endif

endmodule

// File: tb/tb_ab_responder.sv
// Self-checking bench for ab_responder: three configurations share one
// stimulus stream; a timing-based transaction model predicts every output.
module tb_ab_responder;

    localparam int RMAX0 = 32'h7FFF_FFFF;

    logic               clk_top = 1'b0;
    logic               reset_n;
    logic               a1;
    logic               b1;
    logic               c1_0, d1_0, c1_1, d1_1, c1_2, d1_2;
    logic signed [31:0] r1_0, r1_1, r1_2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Transaction view: acc = edge index of the accepted request, -1 when none open
    typedef struct packed {
        int acc;
        bit c1;
        bit d1;
        int cnt;
    } mst_t;

    mst_t m0 = '{acc: -1, c1: 1'b0, d1: 1'b0, cnt: 0};
    mst_t m1 = '{acc: -1, c1: 1'b0, d1: 1'b0, cnt: 0};
    mst_t m2 = '{acc: -1, c1: 1'b0, d1: 1'b0, cnt: 0};

    ab_responder #(.LAT(2)) u_dut0 (
        .clk_top(clk_top), .reset_n(reset_n), .a1(a1), .b1(b1),
        .c1(c1_0), .d1(d1_0), .r1(r1_0)
    );
    ab_responder #(.LAT(1), .R_MAX(3)) u_dut1 (
        .clk_top(clk_top), .reset_n(reset_n), .a1(a1), .b1(b1),
        .c1(c1_1), .d1(d1_1), .r1(r1_1)
    );
    ab_responder #(.LAT(4), .R_MAX(5)) u_dut2 (
        .clk_top(clk_top), .reset_n(reset_n), .a1(a1), .b1(b1),
        .c1(c1_2), .d1(d1_2), .r1(r1_2)
    );

    always #5 clk_top = ~clk_top;

    // Outputs after edge n, from elapsed time since the accepting edge
    function automatic mst_t step_model(mst_t s, int n, logic rn, logic a, logic b,
                                        int lat, int rmax);
        mst_t r;
        r    = s;
        r.d1 = 1'b0;
        if (!rn) begin
            r.acc = -1; r.c1 = 1'b0; r.cnt = 0;
        end else if (s.d1) begin
            r.acc = -1; r.c1 = 1'b0;             // cycle after done: inputs ignored
        end else if (s.acc < 0) begin
            if (a && !b) r.acc = n;
            r.c1 = 1'b0;
        end else if (b) begin
            r.acc = -1; r.c1 = 1'b0;             // abort
        end else if (n - s.acc < lat) begin
            r.c1 = 1'b0;
        end else if (n - s.acc == lat) begin
            r.c1 = 1'b1;                         // acknowledge regardless of a
        end else if (!a) begin
            r.acc = -1; r.c1 = 1'b0; r.d1 = 1'b1;
            r.cnt = (s.cnt < rmax) ? s.cnt + 1 : rmax;
        end else begin
            r.c1 = 1'b1;
        end
        return r;
    endfunction

    // Advance the models on every rising edge with the sampled inputs
    always @(posedge clk_top) begin
        m0  <= step_model(m0, cyc, reset_n, a1, b1, 2, RMAX0);
        m1  <= step_model(m1, cyc, reset_n, a1, b1, 1, 3);
        m2  <= step_model(m2, cyc, reset_n, a1, b1, 4, 5);
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m0_c1", {31'd0, c1_0}, {31'd0, m0.c1});
        chk("m0_d1", {31'd0, d1_0}, {31'd0, m0.d1});
        chk("m0_r1", r1_0, m0.cnt);
        chk("m1_c1", {31'd0, c1_1}, {31'd0, m1.c1});
        chk("m1_d1", {31'd0, d1_1}, {31'd0, m1.d1});
        chk("m1_r1", r1_1, m1.cnt);
        chk("m2_c1", {31'd0, c1_2}, {31'd0, m2.c1});
        chk("m2_d1", {31'd0, d1_2}, {31'd0, m2.d1});
        chk("m2_r1", r1_2, m2.cnt);
    endtask

    // Apply inputs for one rising edge, then compare on the falling edge
    task automatic drive(input logic a, input logic b, input logic rn);
        a1 = a; b1 = b; reset_n = rn;
        @(negedge clk_top);
        if (chk_en) check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
    endtask

    int exp034 [5] = '{1, 2, 3, 3, 3};

    initial begin
        a1 = 1'b0; b1 = 1'b0; reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_c1", {31'd0, c1_0}, 32'd0);
        chk("rst_d1", {31'd0, d1_0}, 32'd0);
        chk("rst_r1", r1_0, 32'd0);
        idle(1);

        // Basic transaction: a1 high for five edges then low
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t030_c1_e1", {31'd0, c1_0}, 32'd0);
        chk("t030_lat1_c1_e1", {31'd0, c1_1}, 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t030_c1_e2", {31'd0, c1_0}, 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t030_c1_e4", {31'd0, c1_0}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t030_c1_done", {31'd0, c1_0}, 32'd0);
        chk("t030_d1_done", {31'd0, d1_0}, 32'd1);
        chk("t030_r1_done", r1_0, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t030_d1_after", {31'd0, d1_0}, 32'd0);
        idle(6);

        // Abort in WAIT, then an immediate new request proves IDLE
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("t031_c1_abort", {31'd0, c1_0}, 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        chk("t031_c1_reacc", {31'd0, c1_0}, 32'd0);
        chk("t031_r1_kept", r1_0, 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t031_c1_ack", {31'd0, c1_0}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t031_r1_done", r1_0, 32'd2);
        idle(6);

        // Request and abort together in IDLE: nothing happens
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            chk("t032_c1", {31'd0, c1_0}, 32'd0);
            chk("t032_d1", {31'd0, d1_0}, 32'd0);
        end
        idle(2);

        // Reset while acknowledging
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t033_c1_ack", {31'd0, c1_0}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("t033_c1_rst", {31'd0, c1_0}, 32'd0);
        chk("t033_r1_rst", r1_0, 32'd0);
        chk("t033_d1_rst", {31'd0, d1_0}, 32'd0);
        drive(1'b0, 1'b0, 1'b1);
        chk("t033_d1_post", {31'd0, d1_0}, 32'd0);
        idle(6);

        // Saturation at R_MAX=3 over five complete transactions
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
            chk("t034_d1", {31'd0, d1_1}, 32'd1);
            chk("t034_r1", r1_1, exp034[k]);
            drive(1'b0, 1'b0, 1'b1);
        end
        idle(2);

        // LAT=1 back-to-back: DONE swallows the held request
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t035_c1_first", {31'd0, c1_1}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t035_d1", {31'd0, d1_1}, 32'd1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t035_c1_in_done", {31'd0, c1_1}, 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        chk("t035_c1_wait", {31'd0, c1_1}, 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        chk("t035_c1_second", {31'd0, c1_1}, 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        idle(6);

        // Randomized traffic including aborts and occasional resets
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 6)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
